blink_stretcher: RTL and testbench

- Output-side counterpart to the button debouncer.
- Converts single-cycle event ticks, such as FIFO write/read ticks or debounced presses, into human-visible LED blinks with a fixed on-time and a fixed off-time.
- Ticks that arrive while a blink is in progress are queued in a saturating pending counter. Every tick therefore produces a distinct blink, up to the counter capacity.
- Sits between the control logic of the FIFO demo and the board LEDs.

---
 rtl/blink_stretcher.sv | 133 +++++++++++++
 tb/tb_blink_stretcher.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_stretcher.sv
// Stretches single-cycle event ticks into visible LED blinks with fixed on/off times.
// Ticks that arrive during a blink are queued in a saturating counter and replayed back-to-back.
module blink_stretcher #(
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int PEND_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 clr_ovf,
  output logic                 led,
  output logic                 busy,
  output logic                 done_tick,
  output logic [PEND_BITS-1:0] pending,
  output logic                 overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [TW-1:0]        r_timer;
  logic [PEND_BITS-1:0] r_pend;
  logic                 r_led;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ovf;

  logic w_tmr_zero;
  logic w_pend_full;
  logic w_pend_empty;
  logic w_last_gap;
  logic w_queue;
  logic w_drop;
  logic w_start_next;
  logic w_pend_dec;

  // A tick in the final gap cycle is consumed directly, so it never touches the queue.
  always_comb begin
    w_tmr_zero   = (r_timer == '0);
    w_pend_full  = (r_pend == '1);
    w_pend_empty = (r_pend == '0);
    w_last_gap   = (r_state == S_GAP) && w_tmr_zero;
    w_queue      = tick && ((r_state == S_ON) || ((r_state == S_GAP) && !w_tmr_zero));
    w_drop       = w_queue && w_pend_full;
    w_start_next = w_last_gap && (tick || !w_pend_empty);
    w_pend_dec   = w_last_gap && !tick && !w_pend_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_pend  <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // A new drop outranks a clear arriving in the same cycle.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;

      if (w_queue && !w_pend_full)
        r_pend <= r_pend + PEND_BITS'(1);
      else if (w_pend_dec)
        r_pend <= r_pend - PEND_BITS'(1);

      case (r_state)
        S_IDLE: begin
          r_led  <= 1'b0;
          r_busy <= 1'b0;
          if (tick) begin
            r_state <= S_ON;
            r_timer <= ON_LOAD;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ON: begin
          if (w_tmr_zero) begin
            r_state <= S_GAP;
            r_timer <= OFF_LOAD;
            r_led   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_GAP: begin
          if (w_tmr_zero) begin
            if (w_start_next) begin
              r_state <= S_ON;
              r_timer <= ON_LOAD;
              r_led   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led       = r_led;
  assign busy      = r_busy;
  assign done_tick = r_done;
  assign pending   = r_pend;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_blink_stretcher.sv
// Bench for blink_stretcher: directed scenarios plus random traffic, checked every cycle
// against a model that tracks the position inside the current blink period.
module tb_blink_stretcher;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PB   = 2;
  localparam int PER  = ON + OFF;
  localparam int PMAX = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          clr_ovf;
  logic          led;
  logic          busy;
  logic          done_tick;
  logic [PB-1:0] pending;
  logic          overflow;

  blink_stretcher #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .PEND_BITS (PB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clr_ovf  (clr_ovf),
    .led      (led),
    .busy     (busy),
    .done_tick(done_tick),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: active blink flag, position 0..PER-1 within the period, queue depth, sticky flag.
  bit m_act = 1'b0;
  int m_pos = 0;
  int m_pend = 0;
  bit m_ovf = 1'b0;

  int   rises = 0;
  logic prev_led = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit t, input bit c, input bit r);
    bit drop;
    drop = 1'b0;
    if (r) begin
      m_act  = 1'b0;
      m_pos  = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
      return;
    end
    if (!m_act) begin
      if (t) begin
        m_act = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == PER - 1) begin
      if (t) begin
        m_pos = 0;
      end else if (m_pend > 0) begin
        m_pend--;
        m_pos = 0;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_pos++;
      if (t) begin
        if (m_pend == PMAX) drop = 1'b1;
        else m_pend++;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic step(input bit t, input bit c, input bit r);
    tick    = t;
    clr_ovf = c;
    rst     = r;
    @(posedge clk);
    model_edge(t, c, r);
    #1;
    chk1("led", led, logic'(m_act && (m_pos < ON)));
    chk1("busy", busy, logic'(m_act));
    chk1("done_tick", done_tick, logic'(m_act && (m_pos == ON)));
    chkn("pending", int'(pending), m_pend);
    chk1("overflow", overflow, logic'(m_ovf));
    if (led === 1'b1 && prev_led === 1'b0) rises++;
    prev_led = led;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b1;
    clr_ovf = 1'b0;
    #1;

    // Reset held two cycles with tick high, then released.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk1("rst_led", led, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkn("rst_pending", int'(pending), 0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_done", done_tick, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);

    // Single blink.
    rises = 0;
    step(1'b1, 1'b0, 1'b0);
    chk1("single_led_c1", led, 1'b1);
    idle(3);
    chk1("single_led_c4", led, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk1("single_done_c5", done_tick, 1'b1);
    idle(2);
    chk1("single_busy_c7", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk1("single_busy_c8", busy, 1'b0);
    chkn("single_rises", rises, 1);
    idle(2);

    // Three ticks back-to-back.
    rises = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chkn("three_pend_c2", int'(pending), 1);
    step(1'b1, 1'b0, 1'b0);
    chkn("three_pend_c3", int'(pending), 2);
    idle(18);
    chk1("three_led_c21", led, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("three_idle_c22", busy, 1'b0);
    chkn("three_rises", rises, 3);
    idle(2);

    // Saturation: six ticks, four blinks, then clear the flag.
    rises = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chkn("sat_pend", int'(pending), PMAX);
    chk1("sat_ovf", overflow, 1'b1);
    idle(4 * PER);
    chkn("sat_rises", rises, 4);
    chk1("sat_ovf_sticky", overflow, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk1("sat_ovf_clr", overflow, 1'b0);
    idle(2);

    // Tick coincident with final gap cycle while pending=1.
    rises = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    chkn("coin_pend", int'(pending), 1);
    chk1("coin_led", led, 1'b1);
    idle(2 * PER + 2);
    chkn("coin_rises", rises, 3);
    chk1("coin_idle", busy, 1'b0);

    // Reset in the middle of an ON phase with a queue and the flag set.
    rises = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    idle(4);
    chkn("mid_pend", int'(pending), 2);
    chk1("mid_ovf", overflow, 1'b1);
    chk1("mid_led", led, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk1("mid_rst_led", led, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chkn("mid_rst_pend", int'(pending), 0);
    chk1("mid_rst_ovf", overflow, 1'b0);
    rises = 0;
    step(1'b1, 1'b0, 1'b0);
    idle(PER);
    chkn("post_rst_rises", rises, 1);
    chk1("post_rst_idle", busy, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 30), ($urandom_range(99) < 5), ($urandom_range(199) == 0));
    end
    idle(PER * (PMAX + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
